// File: rtl/audio_seq_pkg.sv
// rtl/audio_seq_pkg.sv - shared state type and default widths for the audio sample sequencer
// Contents: AUDIO_DATA_W (default sample width), LAT_W (filter latency counter width),
//           seq_state_t (sequencer FSM states).
package audio_seq_pkg;

  localparam int AUDIO_DATA_W = 24;

  // Wide enough for the largest supported filter latency (15).
  localparam int LAT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    SHIFT  = 3'd2,
    WAIT   = 3'd3,
    WRWAIT = 3'd4,
    PUSH   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/audio_sample_sequencer.sv
// rtl/audio_sample_sequencer.sv - per-sample read/shift/write sequencer between the CODEC and the moving-average filter
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   read_ready, readdata_left/right    CODEC sample pair available / data
//   read                               one-cycle pop pulse to the CODEC
//   write_ready, write                 CODEC can accept / one-cycle push pulse
//   sample_left/right, shift_en        captured sample and tap-line advance strobe for the filter
//   filt_left/right                    filter outputs
//   bypass                             1 = return the raw sample instead of the filtered value
//   writedata_left/right               data to the CODEC, held stable through write
//   busy                               sequencer is not idle
//   drop_cnt                           saturating count of writes abandoned on timeout
module audio_sample_sequencer
  import audio_seq_pkg::*;
#(
  parameter int DATA_W     = AUDIO_DATA_W,
  parameter int FILT_LAT   = 1,
  parameter int WR_TIMEOUT = 4096,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              shift_en,
  input  logic [DATA_W-1:0] filt_left,
  input  logic [DATA_W-1:0] filt_right,
  input  logic              bypass,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  // to_cnt must be able to hold WR_TIMEOUT-1, including the WR_TIMEOUT=1 case.
  localparam int              TO_W    = $clog2(WR_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(WR_TIMEOUT - 1);

  seq_state_t        state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_nxt;
  logic [TO_W-1:0]   to_cnt, to_nxt;
  logic [DROP_W-1:0] drop_nxt;
  logic              read_nxt, write_nxt, shift_nxt;
  logic [DATA_W-1:0] sample_l_nxt, sample_r_nxt;
  logic [DATA_W-1:0] wd_l_nxt, wd_r_nxt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      read            <= 1'b0;
      write           <= 1'b0;
      shift_en        <= 1'b0;
      sample_left     <= '0;
      sample_right    <= '0;
      writedata_left  <= '0;
      writedata_right <= '0;
      lat_cnt         <= '0;
      to_cnt          <= '0;
      drop_cnt        <= '0;
    end else begin
      state           <= state_nxt;
      read            <= read_nxt;
      write           <= write_nxt;
      shift_en        <= shift_nxt;
      sample_left     <= sample_l_nxt;
      sample_right    <= sample_r_nxt;
      writedata_left  <= wd_l_nxt;
      writedata_right <= wd_r_nxt;
      lat_cnt         <= lat_nxt;
      to_cnt          <= to_nxt;
      drop_cnt        <= drop_nxt;
    end
  end

  // Pulses (read/write/shift_en) default low so each is high for exactly one
  // cycle; data and counters default to holding their value.
  always_comb begin
    state_nxt    = state;
    read_nxt     = 1'b0;
    write_nxt    = 1'b0;
    shift_nxt    = 1'b0;
    sample_l_nxt = sample_left;
    sample_r_nxt = sample_right;
    wd_l_nxt     = writedata_left;
    wd_r_nxt     = writedata_right;
    lat_nxt      = lat_cnt;
    to_nxt       = to_cnt;
    drop_nxt     = drop_cnt;

    case (state)
      IDLE: begin
        // write_ready is deliberately not looked at here.
        if (read_ready) begin
          sample_l_nxt = readdata_left;
          sample_r_nxt = readdata_right;
          read_nxt     = 1'b1;
          state_nxt    = POP;
        end
      end

      POP: begin
        shift_nxt = 1'b1;
        lat_nxt   = LAT_W'(FILT_LAT);
        state_nxt = SHIFT;
      end

      SHIFT: begin
        state_nxt = WAIT;
      end

      WAIT: begin
        lat_nxt = lat_cnt - 1'b1;
        // Last latency cycle: filt_* reflects the sample shifted in by shift_en.
        if (lat_cnt <= LAT_W'(1)) begin
          wd_l_nxt  = bypass ? sample_left  : filt_left;
          wd_r_nxt  = bypass ? sample_right : filt_right;
          to_nxt    = '0;
          state_nxt = WRWAIT;
        end
      end

      WRWAIT: begin
        if (write_ready) begin
          write_nxt = 1'b1;
          state_nxt = PUSH;
        end else if (to_cnt == TO_LAST) begin
          // Give up on this sample; the CODEC never became ready.
          if (drop_cnt != {DROP_W{1'b1}}) begin
            drop_nxt = drop_cnt + 1'b1;
          end
          state_nxt = IDLE;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end

      PUSH: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// tb/tb_audio_sample_sequencer.sv - scoreboard bench for audio_sample_sequencer with a moving-average filter model
module tb_audio_sample_sequencer;

  localparam int DATA_W     = 24;
  localparam int FILT_LAT   = 3;
  localparam int WR_TIMEOUT = 16;
  localparam int DROP_W     = 8;

  logic              clk;
  logic              rst_n;
  logic              read_ready;
  logic [DATA_W-1:0] readdata_left, readdata_right;
  logic              read;
  logic              write_ready;
  logic              write;
  logic [DATA_W-1:0] sample_left, sample_right;
  logic              shift_en;
  logic [DATA_W-1:0] filt_left, filt_right;
  logic              bypass;
  logic [DATA_W-1:0] writedata_left, writedata_right;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  audio_sample_sequencer #(
    .DATA_W    (DATA_W),
    .FILT_LAT  (FILT_LAT),
    .WR_TIMEOUT(WR_TIMEOUT),
    .DROP_W    (DROP_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_ready     (read_ready),
    .readdata_left  (readdata_left),
    .readdata_right (readdata_right),
    .read           (read),
    .write_ready    (write_ready),
    .write          (write),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .shift_en       (shift_en),
    .filt_left      (filt_left),
    .filt_right     (filt_right),
    .bypass         (bypass),
    .writedata_left (writedata_left),
    .writedata_right(writedata_right),
    .busy           (busy),
    .drop_cnt       (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // 8-tap moving-average filter: tap line advances on shift_en, output
  // delayed so filt_* is valid FILT_LAT cycles after the shift_en cycle.
  logic [DATA_W-1:0] tap_l [8];
  logic [DATA_W-1:0] tap_r [8];
  logic [DATA_W-1:0] pipe_l [FILT_LAT-1];
  logic [DATA_W-1:0] pipe_r [FILT_LAT-1];
  logic [DATA_W+2:0] sum_l, sum_r;

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < 8; i++) begin
      sum_l = sum_l + (DATA_W+3)'(tap_l[i]);
      sum_r = sum_r + (DATA_W+3)'(tap_r[i]);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        tap_l[i] <= '0;
        tap_r[i] <= '0;
      end
      for (int k = 0; k < FILT_LAT-1; k++) begin
        pipe_l[k] <= '0;
        pipe_r[k] <= '0;
      end
    end else begin
      if (shift_en) begin
        tap_l[0] <= sample_left;
        tap_r[0] <= sample_right;
        for (int i = 1; i < 8; i++) begin
          tap_l[i] <= tap_l[i-1];
          tap_r[i] <= tap_r[i-1];
        end
      end
      pipe_l[0] <= sum_l[DATA_W+2:3];
      pipe_r[0] <= sum_r[DATA_W+2:3];
      for (int k = 1; k < FILT_LAT-1; k++) begin
        pipe_l[k] <= pipe_l[k-1];
        pipe_r[k] <= pipe_r[k-1];
      end
    end
  end

  assign filt_left  = pipe_l[FILT_LAT-2];
  assign filt_right = pipe_r[FILT_LAT-2];

  // Scoreboard state
  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
    int                cyc;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] hist_l[$];
  logic [DATA_W-1:0] hist_r[$];
  int checks    = 0;
  int failures  = 0;
  int exp_drops = 0;
  int n_read    = 0;
  int n_shift   = 0;
  int n_write   = 0;
  int last_rd_cyc = -100;
  logic read_q  = 1'b0;
  logic write_q = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: mean of the last eight samples taken, older taps zero.
  function automatic logic [DATA_W-1:0] mov_avg(input logic [DATA_W-1:0] h[$]);
    longint unsigned s = 0;
    int n = h.size();
    for (int i = 0; i < 8 && i < n; i++) s += longint'(h[n-1-i]);
    return DATA_W'(s / 8);
  endfunction

  function automatic exp_t make_exp(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                                    input logic byp, input int at_cyc);
    exp_t e;
    e.l   = byp ? l : mov_avg(hist_l);
    e.r   = byp ? r : mov_avg(hist_r);
    e.cyc = at_cyc;
    return e;
  endfunction

  // Monitor: pulse shape, shift_en placement, and write data/cycle against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (read) begin
        n_read++;
        check("read_single_cycle", 64'(read_q), 64'(0));
        last_rd_cyc = cyc;
      end
      if (shift_en) begin
        n_shift++;
        check("shift_after_read", 64'(cyc), 64'(last_rd_cyc + 1));
      end
      if (write) begin
        n_write++;
        check("write_single_cycle", 64'(write_q), 64'(0));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=write_pulse required=no_write cyc=%0d", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_left", 64'(writedata_left), 64'(e.l));
          check("wr_right", 64'(writedata_right), 64'(e.r));
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
    read_q  = read;
    write_q = write;
  end

  task automatic wait_read(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (read) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL read_timeout actual=no_read required=read_pulse");
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    check("return_idle", 64'(busy), 64'(0));
  endtask

  // One sample; the CODEC becomes write-ready d cycles into WRWAIT (d >= WR_TIMEOUT -> drop).
  task automatic run_sample(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input logic byp, input int d);
    bit got;
    int rc;
    @(negedge clk);
    readdata_left  = l;
    readdata_right = r;
    bypass         = byp;
    write_ready    = 1'b0;
    read_ready     = 1'b1;
    wait_read(got);
    read_ready = 1'b0;
    if (!got) return;
    rc = cyc;
    check("sample_left", 64'(sample_left), 64'(l));
    check("sample_right", 64'(sample_right), 64'(r));
    hist_l.push_back(l);
    hist_r.push_back(r);
    if (d < WR_TIMEOUT) begin
      exp_q.push_back(make_exp(l, r, byp, rc + FILT_LAT + 3 + d));
      repeat (FILT_LAT + 2 + d) @(negedge clk);
    end else begin
      if (exp_drops < (1 << DROP_W) - 1) exp_drops++;
      repeat (FILT_LAT + 2 + WR_TIMEOUT - 1) @(negedge clk);
      check("busy_last_wrwait", 64'(busy), 64'(1));
      @(negedge clk);
      check("idle_after_timeout", 64'(busy), 64'(0));
      check("drop_cnt_step", 64'(drop_cnt), 64'(exp_drops));
      repeat (d - WR_TIMEOUT) @(negedge clk);
    end
    write_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    write_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int rc, prev_rc, r0, s0, w0;

    rst_n          = 1'b0;
    read_ready     = 1'b0;
    write_ready    = 1'b0;
    bypass         = 1'b0;
    readdata_left  = '0;
    readdata_right = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_read", 64'(read), 64'(0));
    check("rst_write", 64'(write), 64'(0));
    check("rst_shift_en", 64'(shift_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    check("rst_writedata", 64'({writedata_left, writedata_right}), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single sample with exact timing; write_ready already high in IDLE.
    readdata_left  = 24'h000800;
    readdata_right = 24'h000010;
    write_ready    = 1'b1;
    read_ready     = 1'b1;
    @(negedge clk);
    rc = cyc;
    check("t1_read", 64'(read), 64'(1));
    check("t1_no_write", 64'(write), 64'(0));
    read_ready = 1'b0;
    hist_l.push_back(24'h000800);
    hist_r.push_back(24'h000010);
    exp_q.push_back(make_exp(24'h000800, 24'h000010, 1'b0, rc + FILT_LAT + 3));
    @(negedge clk);
    check("t2_shift_en", 64'(shift_en), 64'(1));
    check("t2_read_low", 64'(read), 64'(0));
    check("t2_no_write", 64'(write), 64'(0));
    repeat (FILT_LAT) @(negedge clk);
    check("wd_not_yet", 64'(writedata_left), 64'(0));
    @(negedge clk);
    check("wd_left_0100", 64'(writedata_left), 64'(24'h000100));
    check("wd_right_0002", 64'(writedata_right), 64'(24'h000002));
    check("write_not_yet", 64'(write), 64'(0));
    @(negedge clk);
    check("write_pulse", 64'(write), 64'(1));
    @(negedge clk);
    check("write_low", 64'(write), 64'(0));
    check("idle_after_push", 64'(busy), 64'(0));
    write_ready = 1'b0;

    // Bypass: raw sample returned, filter ignored.
    run_sample(DATA_W'($urandom), 24'hABCDEF, 1'b1, 0);

    // Back-to-back with read_ready and write_ready held high.
    r0 = n_read; s0 = n_shift; w0 = n_write;
    bypass      = 1'b0;
    write_ready = 1'b1;
    prev_rc     = 0;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      logic [DATA_W-1:0] l, r;
      l = DATA_W'($urandom);
      r = DATA_W'($urandom);
      readdata_left  = l;
      readdata_right = r;
      read_ready     = 1'b1;
      wait_read(got);
      if (!got) break;
      rc = cyc;
      if (k > 0) check("b2b_spacing", 64'(rc - prev_rc), 64'(FILT_LAT + 5));
      prev_rc = rc;
      hist_l.push_back(l);
      hist_r.push_back(r);
      exp_q.push_back(make_exp(l, r, 1'b0, rc + FILT_LAT + 3));
    end
    read_ready = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    write_ready = 1'b0;
    check("b2b_reads", 64'(n_read - r0), 64'(10));
    check("b2b_shifts", 64'(n_shift - s0), 64'(10));
    check("b2b_writes", 64'(n_write - w0), 64'(10));

    // Randomized samples, write_ready delays straddling the timeout.
    for (int k = 0; k < 40; k++) begin
      run_sample(DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, WR_TIMEOUT + 1)));
    end
    check("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drops));

    // Reset in WAIT: everything clears at once, pending write abandoned.
    @(negedge clk);
    readdata_left  = DATA_W'($urandom);
    readdata_right = DATA_W'($urandom);
    read_ready     = 1'b1;
    wait_read(got);
    read_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("in_wait_busy", 64'(busy), 64'(1));
    w0 = n_write;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", 64'({read, write, shift_en, busy}), 64'(0));
    check("mid_rst_sample", 64'({sample_left, sample_right}), 64'(0));
    check("mid_rst_writedata", 64'({writedata_left, writedata_right}), 64'(0));
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'(0));
    hist_l.delete();
    hist_r.delete();
    exp_drops   = 0;
    write_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_write_after_rst", 64'(n_write - w0), 64'(0));
    check("idle_after_rst", 64'(busy), 64'(0));
    write_ready = 1'b0;

    // Timeout boundaries: ready at the last WRWAIT cycle still writes, one later drops.
    run_sample(DATA_W'($urandom), DATA_W'($urandom), 1'b0, WR_TIMEOUT - 1);
    run_sample(DATA_W'($urandom), DATA_W'($urandom), 1'b0, WR_TIMEOUT);
    check("first_drop", 64'(drop_cnt), 64'(1));

    // Saturation of drop_cnt.
    for (int k = 0; k < 300; k++) begin
      run_sample(DATA_W'($urandom), DATA_W'($urandom), 1'b0, WR_TIMEOUT + 2);
    end
    check("drop_saturated", 64'(drop_cnt), 64'(255));

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_sample_sequencer.md
# audio_sample_sequencer

Sample-rate controller for the audio moving-average datapath. It sits between the audio CODEC handshake (read_ready/read, write_ready/write) and the 8-tap per-channel filter. It consumes each CODEC sample exactly once and advances the filter tap line once per sample instead of every clock. After a fixed filter latency it hands the filtered result back to the CODEC; it drops and counts samples the CODEC will not accept.

## Interface
Parameters:
- DATA_W, 24, sample width per channel
- FILT_LAT, 1, cycles from shift_en cycle to valid filt_* (legal range 1..15)
- WR_TIMEOUT, 4096, max cycles waiting for write_ready before drop (>=1)
- DROP_W, 8, width of drop counter

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  reset, asynchronous, active-low
- read_ready  in  1  CODEC has a sample pair available
- readdata_left / readdata_right  in  DATA_W  CODEC sample pair
- read  out  1  one-cycle pop pulse to CODEC
- write_ready  in  1  CODEC can accept a sample pair
- write  out  1  one-cycle push pulse to CODEC
- sample_left / sample_right  out  DATA_W  captured sample, drives filter tap-line input
- shift_en  out  1  one-cycle tap-line advance strobe
- filt_left / filt_right  in  DATA_W  filter outputs
- bypass  in  1  1 = send raw sample instead of filtered value
- writedata_left / writedata_right  out  DATA_W  data to CODEC, held stable through write
- busy  out  1  state != IDLE
- drop_cnt  out  DROP_W  saturating count of timed-out writes

## Operation
- FSM states: IDLE, POP, SHIFT, WAIT, WRWAIT, PUSH. All outputs are registered except busy, which decodes the state register.
- IDLE: when read_ready=1, capture readdata_* into sample_*, set read=1, go to POP. write_ready is ignored in IDLE, including when it is high at the same time as read_ready.
- POP: read=0, shift_en=1, lat_cnt<=FILT_LAT, go to SHIFT.
- SHIFT: shift_en=0, go to WAIT.
- WAIT: decrement lat_cnt. When lat_cnt==1, latch writedata_* <= bypass ? sample_* : filt_*, to_cnt<=0, go to WRWAIT.
- WRWAIT: if write_ready=1, write=1, go to PUSH. Otherwise to_cnt++. When to_cnt reaches WR_TIMEOUT-1 with write_ready still 0, increment drop_cnt (saturating at all-ones), go to IDLE with no write.
- PUSH: write=0, go to IDLE.
- Width rule: writedata_* passes filt_*/sample_* bit-exact. No arithmetic is done here.
- Reset (any state, mid-operation): state=IDLE; read, write, shift_en=0; sample_*, writedata_*, drop_cnt, lat_cnt, to_cnt=0. A pending write is abandoned with no write pulse.
- drop_cnt clears only on reset.

## Timing
- T = the cycle in which IDLE samples read_ready=1.
- read high in cycle T+1 only. sample_* valid from T+1.
- shift_en high in cycle T+2 only.
- filt_* sampled at end of cycle T+2+FILT_LAT. writedata_* valid from T+3+FILT_LAT.
- If write_ready=1 in WRWAIT cycle W, write is high in W+1 only. IDLE resumes in W+2.
- Minimum turnaround with write_ready held high: read-to-read = FILT_LAT+5 cycles.
- Exactly one read pulse, one shift_en pulse, and at most one write pulse per sample.

## Structure
- Shared package audio_seq_pkg holds the state enum (IDLE..PUSH) and the default DATA_W=24 constant, for reuse by the filter and the top level.
- Single module, no sub-modules. Counters and the FSM are inline.
- The top level connects sample_* and shift_en to the filter tap line, which must use shift_en as its register enable.

## Test plan
- Single sample, FILT_LAT=1: read_ready=1 at T with left=24'h000800, filt_left=24'h000100 at T+3, write_ready high -> read@T+1, shift_en@T+2, writedata_left=24'h000100 from T+4, write@T+5.
- Bypass: bypass=1, readdata_right=24'hABCDEF -> writedata_right=24'hABCDEF; filt ignored.
- Back-to-back: read_ready held high, 10 samples -> exactly 10 read, 10 shift_en, 10 write pulses, spaced FILT_LAT+5 cycles apart.
- Write timeout: WR_TIMEOUT=16, write_ready=0 -> no write pulse, drop_cnt 0->1 after 16 WRWAIT cycles, FSM back in IDLE. Repeat 300 times with DROP_W=8 -> drop_cnt saturates at 255.
- Reset mid-operation: assert rst_n=0 during WAIT -> all outputs 0 and busy=0 immediately; no write pulse after release.
- Simultaneous read_ready and write_ready in IDLE -> only read is issued; write appears only after the WRWAIT/PUSH sequence.
